reg_file: RTL
=============

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter PENDING_W, default 2, giving the width of each register's in-flight write counter (maximum count 2**PENDING_W-1).
REQ-002 SHALL have port clk  input  1  the single clock; every state element updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port rs1_addr  input  5  first source register index.
REQ-005 SHALL have port rs2_addr  input  5  second source register index.
REQ-006 SHALL have port rs1_data  output  arch_reg  first source operand.
REQ-007 SHALL have port rs2_data  output  arch_reg  second source operand.
REQ-008 SHALL have port rs1_busy  output  1  first source has an outstanding write.
REQ-009 SHALL have port rs2_busy  output  1  second source has an outstanding write.
REQ-010 SHALL have port issue_valid  input  1  an instruction is presented for issue.
REQ-011 SHALL have port issue_writes  input  1  the presented instruction writes rd.
REQ-012 SHALL have port issue_rd  input  5  destination index of the presented instruction.
REQ-013 SHALL have port stall  output  1  the presented instruction may not issue this cycle.
REQ-014 SHALL have port wb_valid  input  1  a write-back is present this cycle.
REQ-015 SHALL have port wb_rd  input  5  write-back destination index.
REQ-016 SHALL have port wb_data  input  arch_reg  write-back value, i.e. the selected mem/alu/pc+4 result.

Function
REQ-017 SHALL hold 32 arch_reg entries; x0 SHALL read 0 always, and writes to x0 SHALL be discarded.
REQ-018 SHALL perform reads combinationally from rs1_addr/rs2_addr with zero-cycle latency.
REQ-019 SHALL write wb_data into entry wb_rd at the clock edge when wb_valid=1 and wb_rd!=0.
REQ-020 SHALL keep one PENDING_W-bit counter per register, with x0's counter fixed at 0.
REQ-021 SHALL define an issue as taken when issue_valid=1 and stall=0; a taken issue with issue_writes=1 and issue_rd!=0 SHALL increment counter[issue_rd].
REQ-022 SHALL decrement counter[wb_rd] when wb_valid=1, wb_rd!=0 and the counter is nonzero; a write-back to a counter of 0 SHALL still write the data and SHALL leave the counter at 0.
REQ-023 SHALL leave the counter unchanged when an increment and a decrement target the same register in the same cycle.
REQ-024 SHALL assert rsN_busy when rsN_addr!=0 and counter[rsN_addr]!=0, except as stated in REQ-029.
REQ-025 SHALL compute stall = issue_valid AND (rs1_busy OR rs2_busy OR (issue_writes AND issue_rd!=0 AND counter[issue_rd] at maximum)).
REQ-026 SHALL drive stall=0 whenever issue_valid=0.

Reset
REQ-027 SHALL, while reset=1 at a clock edge, clear all 32 entries to 0 and all counters to 0, and SHALL ignore issue and write-back in that cycle; all outputs SHALL therefore be 0 in the following cycle.

Configuration
REQ-028 SHALL use the macro REG_FILE_BYPASS_EN to compile in or out same-cycle write-to-read forwarding.
REQ-029 SHALL, with REG_FILE_BYPASS_EN defined: when wb_valid=1 and wb_rd=rsN_addr!=0, drive rsN_data=wb_data; and when in addition counter[rsN_addr]<=1, drive rsN_busy=0.
REQ-030 SHALL, without REG_FILE_BYPASS_EN: return the stored (old) value on a same-cycle read, make a write visible from the next cycle, and compute busy from the counter alone.

Structure
REQ-031 SHALL place NUM_ARCH_REGS=32 and reg_addr_t (5-bit) in a shared package reg_file_pkg; arch_reg SHALL come from instructions_pkg.
REQ-032 SHALL implement the counters, busy logic and stall logic as the sub-module reg_scoreboard; the storage array and bypass muxes SHALL stay in reg_file.

Verification
REQ-033 SHALL cover: wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF, with rs1_addr=5 in the same cycle -> rs1_data=0xDEADBEEF with bypass enabled, 0 without; 0xDEADBEEF on the next cycle in both builds.
REQ-034 SHALL cover: write-back to x0 with 0x1234 -> rs1_addr=0 reads 0 and rs1_busy=0 on every cycle.
REQ-035 SHALL cover: issue rd=7 three times, then a fourth issue with rd=7 -> stall=1 with PENDING_W=2; after one write-back to x7 the fourth issue is taken.
REQ-036 SHALL cover: issue rd=3, then present an issue with rs2_addr=3 -> stall=1 until a write-back to x3; with bypass, stall=0 in the write-back cycle itself.
REQ-037 SHALL cover: a taken issue rd=9 and a write-back to x9 in the same cycle while counter[9]=1 -> counter stays 1 and rs1_busy(9)=1 on the next cycle.
REQ-038 SHALL cover: reset asserted with counters nonzero and x4=0x55 -> on the next cycle all busy=0, stall=0 and x4 reads 0.

Source files
------------

// File: rtl/instructions_pkg.sv
// Instruction-level shared types used across the core.
// Latency: n/a (types only).
// Backpressure: n/a.
package instructions_pkg;

    // One architectural register value.
    typedef logic [31:0] arch_reg;

endpackage

// File: rtl/reg_file_pkg.sv
// Register-file constants, index type and small helpers.
// Latency: n/a (types only).
// Backpressure: n/a.
package reg_file_pkg;

    localparam int NUM_ARCH_REGS = 32;

    typedef logic [4:0] reg_addr_t;

    // x0 is hardwired; every other index is a real register.
    function automatic logic addr_live(input reg_addr_t a);
        return a != 5'd0;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// In-flight write counters per register, source busy flags and issue stall.
// Latency: busy/stall combinational from inputs and counters; counters update on clk.
// Backpressure: stall holds the presented instruction when a source is busy or the rd counter is full.
// Build option REG_FILE_BYPASS_EN: a same-cycle write-back retiring the last pending write clears busy.
import reg_file_pkg::*;

module reg_scoreboard #(
    parameter int PENDING_W = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    output logic       rs1_busy,
    output logic       rs2_busy,
    input  logic       issue_valid,
    input  logic       issue_writes,
    input  logic [4:0] issue_rd,
    output logic       stall,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd
);

    localparam logic [PENDING_W-1:0] CNT_ONE = 1;
    localparam logic [PENDING_W-1:0] CNT_MAX = '1;

    logic [PENDING_W-1:0] r_cnt [NUM_ARCH_REGS];

    logic [PENDING_W-1:0] w_cnt_rs1;
    logic [PENDING_W-1:0] w_cnt_rs2;
    logic                 w_rd_full;
    logic                 w_inc;
    logic                 w_dec;
    logic                 w_same;

    assign w_cnt_rs1 = r_cnt[rs1_addr];
    assign w_cnt_rs2 = r_cnt[rs2_addr];

    // Busy flags: outstanding writes, optionally forgiven by a retiring write-back.
    always_comb begin
        rs1_busy = addr_live(rs1_addr) && (w_cnt_rs1 != '0);
        rs2_busy = addr_live(rs2_addr) && (w_cnt_rs2 != '0);
`ifdef REG_FILE_BYPASS_EN
        if (wb_valid && (wb_rd == rs1_addr) && (w_cnt_rs1 <= CNT_ONE)) begin
            rs1_busy = 1'b0;
        end
        if (wb_valid && (wb_rd == rs2_addr) && (w_cnt_rs2 <= CNT_ONE)) begin
            rs2_busy = 1'b0;
        end
`endif
    end

    assign w_rd_full = issue_writes && addr_live(issue_rd) && (r_cnt[issue_rd] == CNT_MAX);
    assign stall     = issue_valid && (rs1_busy || rs2_busy || w_rd_full);

    assign w_inc  = issue_valid && !stall && issue_writes && addr_live(issue_rd);
    assign w_dec  = wb_valid && addr_live(wb_rd) && (r_cnt[wb_rd] != '0);
    assign w_same = w_inc && w_dec && (issue_rd == wb_rd);

    // Counter update; an issue and a retire on the same register cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            if (w_inc && !w_same) begin
                r_cnt[issue_rd] <= r_cnt[issue_rd] + CNT_ONE;
            end
            if (w_dec && !w_same) begin
                r_cnt[wb_rd] <= r_cnt[wb_rd] - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/reg_file.sv
// 32-entry architectural register file with write scoreboard (x0 reads 0).
// Latency: reads combinational; write-back lands at the clock edge.
// Backpressure: stall from reg_scoreboard; build option REG_FILE_BYPASS_EN forwards wb_data to same-cycle reads.
import instructions_pkg::*;
import reg_file_pkg::*;

module reg_file #(
    parameter int PENDING_W = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    output arch_reg    rs1_data,
    output arch_reg    rs2_data,
    output logic       rs1_busy,
    output logic       rs2_busy,
    input  logic       issue_valid,
    input  logic       issue_writes,
    input  logic [4:0] issue_rd,
    output logic       stall,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd,
    input  arch_reg    wb_data
);

    arch_reg r_regs [NUM_ARCH_REGS];

    // Storage write; x0 is never written so it stays at its reset value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_valid && addr_live(wb_rd)) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    // Source reads, with x0 forced to zero and optional write-back forwarding.
    always_comb begin
        rs1_data = addr_live(rs1_addr) ? r_regs[rs1_addr] : '0;
        rs2_data = addr_live(rs2_addr) ? r_regs[rs2_addr] : '0;
`ifdef REG_FILE_BYPASS_EN
        if (wb_valid && addr_live(rs1_addr) && (wb_rd == rs1_addr)) begin
            rs1_data = wb_data;
        end
        if (wb_valid && addr_live(rs2_addr) && (wb_rd == rs2_addr)) begin
            rs2_data = wb_data;
        end
`endif
    end

    reg_scoreboard #(
        .PENDING_W (PENDING_W)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .issue_valid  (issue_valid),
        .issue_writes (issue_writes),
        .issue_rd     (issue_rd),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd)
    );

endmodule
